// File: rtl/cache_fill_arbiter.sv
// rtl/cache_fill_arbiter.sv - cache line-fill arbiter and memory sequencer; CACHE_FILL_ARBITER_ROUND_ROBIN_EN selects round-robin arbitration
module cache_fill_arbiter #(
    parameter int CHANNELS       = 2,
    parameter int ADDR_W         = 16,
    parameter int DATA_W         = 16,
    parameter int WORDS_PER_LINE = 8
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [CHANNELS-1:0]                miss_req,
    input  logic [CHANNELS*ADDR_W-1:0]         miss_addr,
    output logic [CHANNELS-1:0]                miss_grant,
    output logic [CHANNELS-1:0]                miss_done,
    output logic                               mem_en,
    output logic [ADDR_W-1:0]                  mem_addr,
    input  logic [DATA_W-1:0]                  mem_data,
    input  logic                               mem_data_valid,
    output logic                               fill_wr,
    output logic [$clog2(WORDS_PER_LINE)-1:0]  fill_word,
    output logic [DATA_W-1:0]                  fill_data,
    output logic                               fill_tag_wr,
    output logic [ADDR_W-1:0]                  line_base
);
    localparam int WB    = $clog2(WORDS_PER_LINE);
    localparam int CNT_W = WB + 1;
    localparam int CW    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam logic [CNT_W-1:0]  WPL       = CNT_W'(WORDS_PER_LINE);
    localparam logic [CNT_W-1:0]  LAST_WORD = CNT_W'(WORDS_PER_LINE - 1);
    localparam logic [ADDR_W-1:0] BASE_MASK = {ADDR_W{1'b1}} << (WB + 1);

    typedef enum logic [1:0] {S_IDLE, S_FILL, S_DONE} state_t;

    state_t            state;
    logic [CNT_W-1:0]  issue_cnt;
    logic [CNT_W-1:0]  recv_cnt;
    logic              win_found;
    logic [CW-1:0]     win_idx;
    logic [ADDR_W-1:0] win_addr;

`ifdef CACHE_FILL_ARBITER_ROUND_ROBIN_EN
    logic [CW-1:0] rr_ptr;
    logic [CW-1:0] gnt_idx;

    // Scan starts at the pointer and wraps, so the channel just served ranks last.
    always_comb begin
        int j;
        j         = 0;
        win_found = 1'b0;
        win_idx   = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            j = int'(rr_ptr) + k;
            if (j >= CHANNELS) j = j - CHANNELS;
            if (!win_found && miss_req[j]) begin
                win_found = 1'b1;
                win_idx   = CW'(j);
            end
        end
    end
`else
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        for (int k = CHANNELS - 1; k >= 0; k--) begin
            if (miss_req[k]) begin
                win_found = 1'b1;
                win_idx   = CW'(k);
            end
        end
    end
`endif

    assign win_addr    = miss_addr[win_idx*ADDR_W +: ADDR_W];
    assign mem_en      = (state == S_FILL) && (issue_cnt < WPL);
    assign mem_addr    = mem_en ? (line_base + ADDR_W'({issue_cnt, 1'b0})) : '0;
    assign fill_wr     = (state == S_FILL) && mem_data_valid && (recv_cnt < WPL);
    assign fill_word   = fill_wr ? recv_cnt[WB-1:0] : '0;
    assign fill_data   = mem_data;
    assign miss_done   = (state == S_DONE) ? miss_grant : '0;
    assign fill_tag_wr = (state == S_DONE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            issue_cnt  <= '0;
            recv_cnt   <= '0;
            miss_grant <= '0;
            line_base  <= '0;
`ifdef CACHE_FILL_ARBITER_ROUND_ROBIN_EN
            rr_ptr     <= '0;
            gnt_idx    <= '0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (win_found) begin
                        miss_grant <= CHANNELS'(1) << win_idx;
                        line_base  <= win_addr & BASE_MASK;
                        state      <= S_FILL;
`ifdef CACHE_FILL_ARBITER_ROUND_ROBIN_EN
                        gnt_idx    <= win_idx;
`endif
                    end
                end
                S_FILL: begin
                    // Issue and return run independently; only the final return ends the fill.
                    if (mem_en) issue_cnt <= issue_cnt + 1'b1;
                    if (fill_wr) begin
                        recv_cnt <= recv_cnt + 1'b1;
                        if (recv_cnt == LAST_WORD) state <= S_DONE;
                    end
                end
                S_DONE: begin
                    issue_cnt  <= '0;
                    recv_cnt   <= '0;
                    miss_grant <= '0;
                    state      <= S_IDLE;
`ifdef CACHE_FILL_ARBITER_ROUND_ROBIN_EN
                    rr_ptr     <= (int'(gnt_idx) == CHANNELS - 1) ? '0 : gnt_idx + 1'b1;
`endif
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: doc/cache_fill_arbiter.md
Name: cache_fill_arbiter

Overview:
- Multi-channel miss-service controller for the pipelined CPU's cache subsystem.
- Arbitrates line-fill requests from CHANNELS requesters (default 2: I-cache, D-cache).
- Issues word reads to a multi-cycle memory and streams the returned words into the granted cache's data array.
- Sits between the caches and the shared multi-cycle main memory; requesters stall their pipeline stage while their miss_req is high.

Parameters:
- CHANNELS, 2: number of requesters (>=1).
- ADDR_W, 16: byte address width.
- DATA_W, 16: memory word width; words are 2 bytes, so addresses step by 2.
- WORDS_PER_LINE, 8: words per cache line; power of 2, >=2.

Ports:
- clk  in  1  system clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- miss_req  in  CHANNELS  per-channel miss request; level, held until miss_done
- miss_addr  in  CHANNELS*ADDR_W  per-channel miss byte address; channel i at [i*ADDR_W +: ADDR_W]
- miss_grant  out  CHANNELS  one-hot channel currently being filled; 0 when idle
- miss_done  out  CHANNELS  one-cycle pulse on the granted channel when its line is complete
- mem_en  out  1  memory read issue strobe
- mem_addr  out  ADDR_W  memory read byte address
- mem_data  in  DATA_W  memory read data
- mem_data_valid  in  1  mem_data valid this cycle; in-order, one per issued read
- fill_wr  out  1  write strobe into the granted cache data array
- fill_word  out  log2(WORDS_PER_LINE)  word offset within line for fill_wr
- fill_data  out  DATA_W  data for fill_wr (combinational from mem_data)
- fill_tag_wr  out  1  one-cycle strobe: write tag/valid for line_base on the granted channel
- line_base  out  ADDR_W  latched line base address

Behaviour:
- Reset: state IDLE, counters 0, arbitration pointer 0. All outputs 0 in the cycle after rst is sampled high; fill_data follows mem_data.
- Line base: miss_addr with the low log2(WORDS_PER_LINE)+1 bits cleared. Default parameters: addr & 16'hFFF0.
- State IDLE:
  - miss_grant = 0.
  - If any miss_req bit is set: select a winner (see Optional Feature), latch its line_base, set miss_grant one-hot, go to FILL.
  - mem_data_valid in IDLE is ignored.
- State FILL:
  - issue_cnt runs 0..WORDS_PER_LINE-1. Each cycle it is below WORDS_PER_LINE: mem_en=1, mem_addr = line_base + 2*issue_cnt, then issue_cnt increments. One issue per cycle, never stalled.
  - For each mem_data_valid: fill_wr=1, fill_word=recv_cnt, then recv_cnt increments.
  - Valid pulses beyond WORDS_PER_LINE are ignored.
  - When the valid with recv_cnt == WORDS_PER_LINE-1 arrives, go to DONE.
- State DONE, one cycle:
  - miss_done[granted]=1, fill_tag_wr=1, miss_grant unchanged.
  - Clear counters, go to IDLE.
  - The requester drops miss_req on this same edge; IDLE does not re-grant it.
- Grant is held for the whole fill. A later request, or a drop of miss_req mid-fill, never preempts or aborts it; the fill always completes.
- Simultaneous requests in IDLE: exactly one winner; losers stay pending, with miss_grant and miss_done low for them.
- Back-to-back: a pending loser is granted on the IDLE cycle that follows DONE. There is a minimum one idle cycle between fills.
- Reset mid-fill: return to IDLE immediately and drop every output. In-flight memory returns after reset are ignored while in IDLE.
- Latency: grant at cycle G (first FILL cycle); mem_en high for G..G+WORDS_PER_LINE-1. With memory latency L (valid L cycles after issue), miss_done is at G+WORDS_PER_LINE-1+L+1.

Optional Feature:
- Macro: CACHE_FILL_ARBITER_ROUND_ROBIN_EN.
- Defined:
  - A round-robin pointer is updated in DONE to (granted index + 1) mod CHANNELS.
  - Winner is the first requesting channel at or above the pointer, wrapping around.
  - Guarantees no starvation.
- Undefined:
  - Fixed priority: the lowest-index requesting channel wins. Channel 0 (I-cache) has highest priority.
  - No pointer register exists.

Test Plan:
- Single miss: miss_req=2'b01, addr0=16'h1236, bench latency 4.
  - Expected: line_base=16'h1230; mem_addr sequence 1230,1232,...,123E over 8 cycles.
  - Expected: fill_word 0..7 carries the matching data; miss_done=2'b01 exactly 12 cycles after grant; fill_tag_wr pulses once.
- Simultaneous: miss_req=2'b11, addr0=16'h0040, addr1=16'h8004.
  - Expected: channel 0 filled first (line 0x0040), then channel 1 (line 0x8000) granted one cycle after DONE.
- Fairness with CACHE_FILL_ARBITER_ROUND_ROBIN_EN:
  - Both channels re-request continuously for 4 fills. Expected grant order 0,1,0,1.
  - Without the macro, expected grant order 0,0,0,0.
- Reset mid-fill: assert rst after 3 fill_wr pulses.
  - Expected next cycle: all outputs 0, state IDLE.
  - Stray mem_data_valid pulses in the following cycles produce no fill_wr.
- Request drop mid-fill: miss_req 1->0 at word 2.
  - Expected: all 8 words still written; miss_done pulses; no further grant.
- Extra valid: bench returns 9 valid pulses. Expected: exactly 8 fill_wr pulses, 9th ignored, single miss_done.
